// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the text-overlay stage.
//   CHAR_W/CHAR_H : glyph cell size in pixels
//   TXT_COLS/ROWS : text grid size in characters
//   WIN_W/WIN_H   : text window size derived from the above
//   vga_timing_t  : coordinate + sync/blank bundle carried to the outputs
//   pix_ctx_t     : per-pixel context needed by the compositing stage
package vga_pkg;
  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int TXT_COLS = 16;
  localparam int TXT_ROWS = 16;
  localparam int WIN_W    = CHAR_W * TXT_COLS;
  localparam int WIN_H    = CHAR_H * TXT_ROWS;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_timing_t;

  typedef struct packed {
    logic        in_win;
    logic [2:0]  dx_lo;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } pix_ctx_t;

  // Glyph bit 7 is the leftmost pixel of the cell.
  function automatic logic glyph_bit(input logic [7:0] pixels, input logic [2:0] dx_lo);
    return pixels[3'd7 - dx_lo];
  endfunction
endpackage

// File: rtl/draw_rect_char_if.sv
// draw_rect_char_if: link between the overlay stage and the char-code/font ROM pair.
//   char_xy     : {row[3:0], col[3:0]} address into the char-code ROM
//   char_line   : glyph row index into the font ROM
//   char_pixels : glyph row returned by the font ROM (bit 7 = leftmost pixel)
// master = overlay stage, slave = ROM pair.
interface draw_rect_char_if;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [7:0] char_pixels;

  modport master (output char_xy, output char_line, input char_pixels);
  modport slave  (input char_xy, input char_line, output char_pixels);
endinterface

// File: rtl/draw_rect_char_sig_delay.sv
// sig_delay: fixed-length register chain with synchronous active-low reset.
//   clk, rst_n : pixel clock, synchronous reset (active low)
//   din        : WIDTH-bit input
//   dout       : din delayed by CLK_DEL clocks (CLK_DEL >= 1), registered
module sig_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage [CLK_DEL];

  // Shift chain; reset clears every stage so a flush leaves no stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) stage[i] <= {WIDTH{1'b0}};
    end else begin
      stage[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[CLK_DEL-1];
endmodule

// File: rtl/draw_rect_char.sv
// draw_rect_char: text-overlay stage of the VGA pixel chain.
// Generates ROM addresses for a 16x16-character window at (X_POS, Y_POS) and
// overlays TEXT_COLOR where the returned glyph bit is set. Fixed 3-clock latency.
//   clk, rst_n              : pixel clock, synchronous active-low reset
//   hcount_in/vcount_in     : pixel coordinates
//   hsync/vsync/hblnk/vblnk : VGA timing inputs, *_out delayed by 3 clocks
//   rgb_in / rgb_out        : upstream colour / composited colour (RGB444)
//   rom                     : char_xy/char_line out, char_pixels in (valid 2 clocks after pixel)
// Build option: define DRAW_RECT_CHAR_BG_EN to fill glyph-0 window pixels with BG_COLOR;
// otherwise the text is transparent over rgb_in.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter logic [10:0] X_POS      = 11'd64,
  parameter logic [10:0] Y_POS      = 11'd64,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             hcount_in,
  input  logic [10:0]             vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblnk_in,
  input  logic                    vblnk_in,
  input  logic [11:0]             rgb_in,
  draw_rect_char_if.master        rom,
  output logic [10:0]             hcount_out,
  output logic [10:0]             vcount_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    hblnk_out,
  output logic                    vblnk_out,
  output logic [11:0]             rgb_out
);
  localparam logic [11:0] X_END = {1'b0, X_POS} + 12'(WIN_W);
  localparam logic [11:0] Y_END = {1'b0, Y_POS} + 12'(WIN_H);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_win;
  logic [7:0]  char_xy_q;
  logic [3:0]  char_line_q;
  pix_ctx_t    ctx_in;
  pix_ctx_t    ctx_s2;
  vga_timing_t tim_in;
  vga_timing_t tim_out;
  logic [11:0] rgb_next;
  logic        unused_bits;

  // Offsets wrap outside the window; in_win keeps them from being used there.
  assign dx     = hcount_in - X_POS;
  assign dy     = vcount_in - Y_POS;
  assign in_win = (hcount_in >= X_POS) && ({1'b0, hcount_in} < X_END) &&
                  (vcount_in >= Y_POS) && ({1'b0, vcount_in} < Y_END);

  // S1: ROM address and glyph row; zero outside the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_xy_q   <= 8'd0;
      char_line_q <= 4'd0;
    end else if (in_win) begin
      char_xy_q   <= {dy[7:4], dx[6:3]};
      char_line_q <= dy[3:0];
    end else begin
      char_xy_q   <= 8'd0;
      char_line_q <= 4'd0;
    end
  end

  assign rom.char_xy   = char_xy_q;
  assign rom.char_line = char_line_q;

  // S1+S2 context, lined up with char_pixels coming back from the font ROM.
  assign ctx_in = '{in_win: in_win, dx_lo: dx[2:0], hblnk: hblnk_in,
                    vblnk: vblnk_in, rgb: rgb_in};

  sig_delay #(.WIDTH($bits(pix_ctx_t)), .CLK_DEL(2)) u_ctx_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ctx_in),
    .dout  (ctx_s2)
  );

  // Coordinates and sync/blank go straight through the 3-stage chain.
  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  sig_delay #(.WIDTH($bits(vga_timing_t)), .CLK_DEL(3)) u_timing_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tim_in),
    .dout  (tim_out)
  );

  assign hcount_out = tim_out.hcount;
  assign vcount_out = tim_out.vcount;
  assign hsync_out  = tim_out.hsync;
  assign vsync_out  = tim_out.vsync;
  assign hblnk_out  = tim_out.hblnk;
  assign vblnk_out  = tim_out.vblnk;

  // Compositing: blanking wins, then set glyph bits, then window fill/pass-through.
  always_comb begin
    rgb_next = ctx_s2.rgb;
    if (ctx_s2.hblnk || ctx_s2.vblnk) begin
      rgb_next = 12'h000;
    end else if (ctx_s2.in_win && glyph_bit(rom.char_pixels, ctx_s2.dx_lo)) begin
      rgb_next = TEXT_COLOR;
    end else if (ctx_s2.in_win) begin
`ifdef DRAW_RECT_CHAR_BG_EN
      rgb_next = BG_COLOR;
`else
      rgb_next = ctx_s2.rgb;
`endif
    end else begin
      rgb_next = ctx_s2.rgb;
    end
  end

  // S3: registered colour output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out <= 12'h000;
    end else begin
      rgb_out <= rgb_next;
    end
  end

  // Offset high bits only matter for the window test, which uses the raw counts.
`ifdef DRAW_RECT_CHAR_BG_EN
  assign unused_bits = ^{dx[10:7], dy[10:8]};
`else
  assign unused_bits = ^{dx[10:7], dy[10:8], BG_COLOR};
`endif
endmodule

// File: doc/draw_rect_char.md
# draw_rect_char

Text-overlay stage of the VGA pixel chain. Computes the text-grid address (`char_xy`) and glyph row (`char_line`) for each pixel inside a 16×16-character window, and receives the glyph byte back from the character-code ROM and font ROM pair. It then overlays text-colour pixels onto the incoming RGB stream, with all VGA timing signals delayed to match. Sits between the background/rectangle drawing stages and the mouse/output stage.

## Interface

Parameters:
- `X_POS`, 64, left edge of text window in pixels (11 bit).
- `Y_POS`, 64, top edge of text window in pixels (11 bit).
- `TEXT_COLOR`, 12'hFFF, RGB444 colour of set glyph pixels.
- `BG_COLOR`, 12'h000, RGB444 window fill; used only with `DRAW_RECT_CHAR_BG_EN`.

Ports:
- `clk` in 1: pixel clock; every register is clocked on its rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `hcount_in`, `vcount_in` in 11 each: pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1 each: VGA timing signals.
- `rgb_in` in 12: upstream pixel colour.
- `char_pixels` in 8: glyph row from the font ROM; bit 7 is the leftmost pixel.
- `char_xy` out 8: `{row[3:0], col[3:0]}` address to the character-code ROM.
- `char_line` out 4: glyph row index to the font ROM.
- `hcount_out`, `vcount_out` out 11 each: coordinates delayed by 3 cycles.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out 1 each: timing signals delayed by 3 cycles.
- `rgb_out` out 12: composited pixel colour.

## Operation

- Glyph cell is 8 wide × 16 high, so the window is 128 × 256 px.
- `in_win` = (`hcount` ≥ X_POS) && (`hcount` < X_POS+128) && (`vcount` ≥ Y_POS) && (`vcount` < Y_POS+256).
- Offsets are computed as `dx = hcount - X_POS` and `dy = vcount - Y_POS`, both 11 bit.
  - `col = dx[6:3]`, `row = dy[7:4]`, `char_line = dy[3:0]`.
  - Outside the window, `char_xy` and `char_line` are 0.
  - The subtraction may wrap outside the window; this is harmless because `in_win` gates its use.
- Pipeline:
  - **S1** registers `char_xy`, `char_line`, `in_win`, `dx[2:0]`, the timing signals and `rgb`.
  - The external char-code ROM is combinational. The font ROM registers once, so `char_pixels` is valid in **S2**.
  - **S2** delays the S1 data by one more cycle.
  - **S3** registers the outputs: if `in_win` and `char_pixels[7 - dx[2:0]]` is set, `rgb_out = TEXT_COLOR`. Otherwise `rgb_out` follows the `DRAW_RECT_CHAR_BG_EN` rule.
- During blanking (`hblnk` or `vblnk` at S3), `rgb_out = 12'h000` regardless of window or glyph.
- The block contains no state machine; behaviour is a pure fixed-latency pipeline.

## Timing

- Latency from any input to the corresponding output is exactly 3 clocks. `hcount_out(t) = hcount_in(t-3)`.
- `char_xy` and `char_line` appear 1 clock after their source `hcount`/`vcount`.
- `char_pixels` is sampled 2 clocks after the same source pixel.
- Reset: while `rst_n`=0 at a clock edge, every pipeline register and every output clears to 0. This includes `char_xy`, `char_line` and `rgb_out`.
  - After reset is released, outputs are valid from the 3rd clock onward.
  - Reset mid-frame simply flushes the pipeline; there is no recovery sequence.
- Boundary columns:
  - `hcount = X_POS` uses glyph bit 7.
  - `hcount = X_POS+127` uses bit 0 of col 15.
  - `hcount = X_POS+128` is outside the window.
- Boundary rows: `vcount = Y_POS+255` gives `row` 15, `char_line` 15.

## Configuration

- `DRAW_RECT_CHAR_BG_EN` defined: inside the window, glyph-0 pixels output `BG_COLOR`.
- Macro undefined: glyph-0 pixels pass the delayed `rgb_in` (transparent text).
- Outside the window, the delayed `rgb_in` passes through in both builds.

## Structure

- Shared constants in `vga_pkg`: `CHAR_W`=8, `CHAR_H`=16, `TXT_COLS`=16, `TXT_ROWS`=16.
- Window width and height are derived from these constants, not hard-coded.
- One sub-module, `sig_delay`, delays the timing/coordinate bundle.
  - Parameters: `WIDTH`, `CLK_DEL`.
  - Uses the same `clk`/`rst_n`.
  - Instantiated for the 3-stage timing path.

## Test plan

- **Reset:** hold `rst_n`=0 for 5 clocks with random inputs → every output is 0. Release `rst_n` → the first valid `hcount_out` equals `hcount_in` from 3 clocks earlier.
- **Address generation:** `hcount`=64+8·5+2, `vcount`=64+16·1+7 → one clock later `char_xy`=8'h15 and `char_line`=4'h7.
- **Glyph overlay:** drive `char_pixels`=8'b1000_0001 across the cell at X_POS..X_POS+7 with `rgb_in`=12'h123, macro undefined → `rgb_out` sequence is FFF, 123×6, FFF, 3 clocks later.
- **Background build:** same stimulus with `DRAW_RECT_CHAR_BG_EN` defined and BG_COLOR=12'h00F → the six middle pixels are 00F.
- **Window edges:** `hcount`=X_POS+128 with `char_pixels`=8'hFF → `rgb_out` equals the delayed `rgb_in`, and `char_xy`=0.
- **Blanking and full frame:** `hblnk_in`=1 inside the window with `char_pixels`=8'hFF → `rgb_out`=12'h000. Run a full 800×600 frame with the real char-code ROM and font ROM → the text window renders, and sync pulse edges are shifted by exactly 3 clocks.
